cpu_controller: RTL
===================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter REG_WIDTH, 16, datapath and instruction width.
REQ-002 Parameter REG_ADDR_BITS, 4, register-file address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 instr  input  REG_WIDTH  instruction word from instruction memory.
REQ-006 instrValid  input  1  instr holds a valid word this cycle.
REQ-007 step  input  1  single-step advance pulse; used only under CPU_CTRL_STEP_EN.
REQ-008 instrReq  output  1  fetch request to instruction memory.
REQ-009 regAddressA, regAddressB  output  REG_ADDR_BITS each  source and destination register addresses.
REQ-010 srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable, pcEnable, aluOutputRegEnable, regWriteEnable  output  1 each  datapath register enables.
REQ-011 aluInputAMuxSelect, aluInputBMuxSelect  output  1 each  ALU A mux (0 = register, 1 = PC); ALU B mux (0 = register, 1 = immediate).
REQ-012 aluOpCode  output  4  ALU operation code.
REQ-013 instrType  output  1  0 = R-type, 1 = I-type.
REQ-014 immediate  output  REG_WIDTH  value presented to the immediate register.
REQ-015 halted  output  1  controller is in HALT.

Function
REQ-016 Instruction fields: op = instr[15:12], rdest = instr[11:8], opext = instr[7:4], rsrc = instr[3:0]; imm8 = instr[7:0].
REQ-017 Decode rules: op 0x0 is R-type with aluOpCode = opext; op 0x1-0xE is I-type with aluOpCode = op and immediate = sign-extended imm8; op 0xF is HALT.
REQ-018 The FSM has the states FETCH, DECODE, EXECUTE, WRITEBACK, PCLOAD, PCINC and HALT, plus STEPWAIT when the step feature is compiled in.
REQ-019 FETCH: instrReq=1; on instrValid=1, capture instr into the internal IR and go to DECODE; otherwise hold in FETCH with no timeout.
REQ-020 DECODE: regAddressA=rsrc, regAddressB=rdest, src/dstAddressRegEnable=1, immediateRegEnable=instrType; go to EXECUTE, or to HALT if op=0xF.
REQ-021 EXECUTE: aluInputAMuxSelect=0, aluInputBMuxSelect=instrType, aluOutputRegEnable=1; go to WRITEBACK.
REQ-022 WRITEBACK: regWriteEnable=1 for exactly one cycle with EXECUTE's mux and opcode values held; go to PCLOAD.
REQ-023 PCLOAD: immediate=1, immediateRegEnable=1; go to PCINC.
REQ-024 PCINC: aluInputAMuxSelect=1, aluInputBMuxSelect=1, aluOpCode=OP_ADD, pcEnable=1 for one cycle; go to FETCH (or STEPWAIT).
REQ-025 Latency: 6 cycles per instruction when instrValid is high on the first FETCH cycle; each FETCH stall cycle adds one.
REQ-026 All enables not listed for a state are 0; outputs are registered or decoded from state and IR only, never from instr directly.
REQ-027 instrValid is ignored outside FETCH.
REQ-028 HALT is terminal: all enables and instrReq are 0 and halted=1 until reset.
REQ-029 regWriteEnable and pcEnable are never high in the same cycle.

Reset
REQ-030 On reset=1 at a clock edge, from any state including mid-instruction: state=FETCH, IR=0, and on the next cycle all enables, mux selects, aluOpCode, instrType, immediate, regAddressA/B and halted are 0.
REQ-031 instrReq=1 in the first cycle after reset deasserts.

Configuration
REQ-032 The macro CPU_CTRL_STEP_EN, when defined, makes PCINC go to STEPWAIT; STEPWAIT holds with all enables at 0 until step=1, then goes to FETCH.
REQ-033 When CPU_CTRL_STEP_EN is not defined, PCINC goes directly to FETCH, STEPWAIT does not exist and step is ignored.

Structure
REQ-034 The package cpu_ctrl_pkg holds the state enum, field bit positions, OP_ADD (4'h5), OP_HALT (4'hF) and the INSTR_R/INSTR_I constants.
REQ-035 A combinational sub-module cpu_ctrl_decode maps IR to aluOpCode, instrType, immediate and isHalt; the FSM stays in cpu_controller.

Verification
REQ-036 R-type: instr=16'h0352, instrValid high in FETCH -> DECODE A=2, B=3; EXECUTE B-sel=0, aluOpCode=5; regWriteEnable pulses exactly once; PCINC pcEnable=1; back in FETCH after 6 cycles.
REQ-037 I-type: instr=16'h52F0 -> instrType=1, immediate=16'hFFF0, immediateRegEnable=1 in DECODE, aluInputBMuxSelect=1 in EXECUTE.
REQ-038 Stall: instrValid held low for 3 cycles in FETCH -> instrReq stays 1, no enable asserts, instruction completes in 9 cycles.
REQ-039 Halt: instr=16'hF000 -> HALT after DECODE, halted=1, no regWriteEnable/pcEnable pulses for 20 cycles; reset returns to FETCH.
REQ-040 Mid-op reset: reset asserted during WRITEBACK -> all outputs 0 the next cycle, then FETCH with instrReq=1.
REQ-041 With CPU_CTRL_STEP_EN: the controller waits in STEPWAIT after PCINC; a one-cycle step pulse starts the next FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU controller.
// STEPWAIT exists only when CPU_CTRL_STEP_EN is defined.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_PCLOAD    = 3'd4,
    ST_PCINC     = 3'd5,
    ST_HALT      = 3'd6
`ifdef CPU_CTRL_STEP_EN
    ,ST_STEPWAIT = 3'd7
`endif
  } state_e;

  // Instruction field bit positions (16-bit encoding)
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RDEST_MSB = 11;
  localparam int RDEST_LSB = 8;
  localparam int OPEXT_MSB = 7;
  localparam int OPEXT_LSB = 4;
  localparam int RSRC_MSB  = 3;
  localparam int RSRC_LSB  = 0;
  localparam int IMM8_MSB  = 7;
  localparam int IMM8_LSB  = 0;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic INSTR_R = 1'b0;
  localparam logic INSTR_I = 1'b1;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decoder: IR -> ALU opcode, instruction type,
// sign-extended immediate and halt flag.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_WIDTH = 16
) (
  input  logic [REG_WIDTH-1:0] ir_i,
  output logic [3:0]           alu_op_o,
  output logic                 instr_type_o,
  output logic [REG_WIDTH-1:0] immediate_o,
  output logic                 is_halt_o
);

  logic [3:0] op;
  logic [3:0] opext;
  logic [7:0] imm8;
  logic       unused_rdest;

  assign op    = ir_i[OP_MSB:OP_LSB];
  assign opext = ir_i[OPEXT_MSB:OPEXT_LSB];
  assign imm8  = ir_i[IMM8_MSB:IMM8_LSB];

  // The destination field is routed by the controller, not decoded here.
  assign unused_rdest = ^ir_i[RDEST_MSB:RDEST_LSB];

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    alu_op_o     = opext;
    instr_type_o = INSTR_R;
    immediate_o  = '0;
    is_halt_o    = 1'b0;
    if (op == OP_HALT) begin
      alu_op_o  = OP_HALT;
      is_halt_o = 1'b1;
    end else if (op != OP_RTYPE) begin
      alu_op_o     = op;
      instr_type_o = INSTR_I;
      immediate_o  = {{(REG_WIDTH-8){imm8[7]}}, imm8};
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXECUTE/WRITEBACK/PCLOAD/PCINC/HALT.
// Define CPU_CTRL_STEP_EN to add a STEPWAIT state released by the step input.
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_WIDTH-1:0]     instr,
  input  logic                     instrValid,
  input  logic                     step,
  output logic                     instrReq,
  output logic [REG_ADDR_BITS-1:0] regAddressA,
  output logic [REG_ADDR_BITS-1:0] regAddressB,
  output logic                     srcAddressRegEnable,
  output logic                     dstAddressRegEnable,
  output logic                     immediateRegEnable,
  output logic                     pcEnable,
  output logic                     aluOutputRegEnable,
  output logic                     regWriteEnable,
  output logic                     aluInputAMuxSelect,
  output logic                     aluInputBMuxSelect,
  output logic [3:0]               aluOpCode,
  output logic                     instrType,
  output logic [REG_WIDTH-1:0]     immediate,
  output logic                     halted
);

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] ir_q, ir_d;

  logic [3:0]           dec_op;
  logic                 dec_type;
  logic [REG_WIDTH-1:0] dec_imm;
  logic                 dec_halt;

`ifndef CPU_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  cpu_ctrl_decode #(.REG_WIDTH(REG_WIDTH)) u_decode (
    .ir_i        (ir_q),
    .alu_op_o    (dec_op),
    .instr_type_o(dec_type),
    .immediate_o (dec_imm),
    .is_halt_o   (dec_halt)
  );

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (instrValid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE:    state_d = dec_halt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_PCLOAD;
      ST_PCLOAD:    state_d = ST_PCINC;
`ifdef CPU_CTRL_STEP_EN
      ST_PCINC:     state_d = ST_STEPWAIT;
      ST_STEPWAIT:  if (step) state_d = ST_FETCH;
`else
      ST_PCINC:     state_d = ST_FETCH;
`endif
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Outputs depend only on state and IR, never on the live instr bus.
  always_comb begin
    instrReq            = 1'b0;
    regAddressA         = '0;
    regAddressB         = '0;
    srcAddressRegEnable = 1'b0;
    dstAddressRegEnable = 1'b0;
    immediateRegEnable  = 1'b0;
    pcEnable            = 1'b0;
    aluOutputRegEnable  = 1'b0;
    regWriteEnable      = 1'b0;
    aluInputAMuxSelect  = 1'b0;
    aluInputBMuxSelect  = 1'b0;
    aluOpCode           = '0;
    instrType           = INSTR_R;
    immediate           = '0;
    halted              = 1'b0;
    case (state_q)
      ST_FETCH: instrReq = 1'b1;
      ST_DECODE: begin
        regAddressA         = REG_ADDR_BITS'(ir_q[RSRC_MSB:RSRC_LSB]);
        regAddressB         = REG_ADDR_BITS'(ir_q[RDEST_MSB:RDEST_LSB]);
        srcAddressRegEnable = 1'b1;
        dstAddressRegEnable = 1'b1;
        immediateRegEnable  = dec_type;
        instrType           = dec_type;
        immediate           = dec_imm;
        aluOpCode           = dec_op;
      end
      ST_EXECUTE, ST_WRITEBACK: begin
        aluOutputRegEnable = (state_q == ST_EXECUTE);
        regWriteEnable     = (state_q == ST_WRITEBACK);
        aluInputBMuxSelect = dec_type;
        aluOpCode          = dec_op;
        instrType          = dec_type;
        immediate          = dec_imm;
      end
      ST_PCLOAD: begin
        immediate          = REG_WIDTH'(1);
        immediateRegEnable = 1'b1;
      end
      ST_PCINC: begin
        aluInputAMuxSelect = 1'b1;
        aluInputBMuxSelect = 1'b1;
        aluOpCode          = OP_ADD;
        pcEnable           = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
